// File: rtl/barrel_shift_arbiter.sv
// Round-robin arbiter sharing one 32-bit log barrel shifter among NUM_REQ
// requesters, with a single-entry result register tagged by requester ID.
//
// Ports:
//   clk, rst              clock, async active-high reset
//   req_valid/req_ready   per-requester handshake (ready = granted now)
//   req_data/req_cmd      packed 32-bit operands / 8-bit commands
//   res_valid/res_ready   result handshake
//   res_data/res_id       registered result and issuing requester
//   ops_done              16-bit count of consumed results (wraps)
module barrel_shift_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int ID_W    = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_REQ-1:0]    req_valid,
    output logic [NUM_REQ-1:0]    req_ready,
    input  logic [32*NUM_REQ-1:0] req_data,
    input  logic [8*NUM_REQ-1:0]  req_cmd,
    output logic                  res_valid,
    input  logic                  res_ready,
    output logic [31:0]           res_data,
    output logic [ID_W-1:0]       res_id,
    output logic [15:0]           ops_done
);

    typedef enum logic {
        EMPTY,
        FULL
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [ID_W-1:0] ptr;
    logic [ID_W-1:0] gnt_id;
    logic [ID_W:0]   cand;
    logic            gnt_any;
    logic            can_accept;
    logic            accept;
    logic [31:0]     op_data;
    logic [7:0]      op_cmd;
    logic [31:0]     shf_in;
    logic [31:0]     shf_out;
    logic [31:0]     result;
    logic            sh_right;
    logic            sh_rot;
    logic            sh_fill;

    function automatic logic [31:0] bitrev(input logic [31:0] v);
        logic [31:0] r;
        for (int i = 0; i < 32; i++) begin
            r[i] = v[31-i];
        end
        return r;
    endfunction

    assign res_valid  = (state == FULL);
    assign can_accept = !res_valid || res_ready;
    assign accept     = !rst && can_accept && gnt_any;

    // Scan upward from the pointer, wrapping at NUM_REQ.
    always_comb begin
        gnt_any = 1'b0;
        gnt_id  = '0;
        cand    = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = {1'b0, ptr} + (ID_W+1)'(k);
            if (cand >= (ID_W+1)'(NUM_REQ)) begin
                cand = cand - (ID_W+1)'(NUM_REQ);
            end
            if (!gnt_any && req_valid[cand[ID_W-1:0]]) begin
                gnt_any = 1'b1;
                gnt_id  = cand[ID_W-1:0];
            end
        end
    end

    always_comb begin
        req_ready = '0;
        if (accept) begin
            req_ready[gnt_id] = 1'b1;
        end
    end

    always_comb begin
        op_data = '0;
        op_cmd  = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (gnt_id == ID_W'(k)) begin
                op_data = req_data[32*k +: 32];
                op_cmd  = req_cmd[8*k +: 8];
            end
        end
    end

    // Left operations run through the right-shift network on a
    // bit-reversed operand, then get reversed back.
    assign sh_right = op_cmd[5];
    assign sh_rot   = op_cmd[6];
    assign sh_fill  = sh_right && !sh_rot && op_cmd[7] && op_data[31];
    assign shf_in   = sh_right ? op_data : bitrev(op_data);

    always_comb begin
        shf_out = shf_in;
        if (op_cmd[0]) begin
            shf_out = sh_rot ? {shf_out[0], shf_out[31:1]}
                             : {sh_fill, shf_out[31:1]};
        end
        if (op_cmd[1]) begin
            shf_out = sh_rot ? {shf_out[1:0], shf_out[31:2]}
                             : {{2{sh_fill}}, shf_out[31:2]};
        end
        if (op_cmd[2]) begin
            shf_out = sh_rot ? {shf_out[3:0], shf_out[31:4]}
                             : {{4{sh_fill}}, shf_out[31:4]};
        end
        if (op_cmd[3]) begin
            shf_out = sh_rot ? {shf_out[7:0], shf_out[31:8]}
                             : {{8{sh_fill}}, shf_out[31:8]};
        end
        if (op_cmd[4]) begin
            shf_out = sh_rot ? {shf_out[15:0], shf_out[31:16]}
                             : {{16{sh_fill}}, shf_out[31:16]};
        end
    end

    assign result = sh_right ? shf_out : bitrev(shf_out);

    always_comb begin
        state_nxt = state;
        unique case (state)
            EMPTY: begin
                if (accept) state_nxt = FULL;
            end
            FULL: begin
                if (accept)         state_nxt = FULL;
                else if (res_ready) state_nxt = EMPTY;
            end
            default: state_nxt = EMPTY;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= EMPTY;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            res_data <= '0;
            res_id   <= '0;
            ptr      <= '0;
        end else if (accept) begin
            res_data <= result;
            res_id   <= gnt_id;
            if (gnt_id == ID_W'(NUM_REQ-1)) ptr <= '0;
            else                           ptr <= gnt_id + ID_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ops_done <= '0;
        end else if (res_valid && res_ready) begin
            ops_done <= ops_done + 16'd1;
        end
    end

endmodule

// File: tb/tb_barrel_shift_arbiter.sv
// Scoreboard bench for barrel_shift_arbiter: directed vectors, arbitration,
// stall, mid-run reset and randomized traffic against a reference model.
module tb_barrel_shift_arbiter;

    localparam int N  = 2;
    localparam int IW = 1;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [N-1:0]    req_valid = '0;
    logic [N-1:0]    req_ready;
    logic [32*N-1:0] req_data = '0;
    logic [8*N-1:0]  req_cmd = '0;
    logic            res_valid;
    logic            res_ready = 1'b0;
    logic [31:0]     res_data;
    logic [IW-1:0]   res_id;
    logic [15:0]     ops_done;

    barrel_shift_arbiter #(.NUM_REQ(N), .ID_W(IW)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_data(req_data), .req_cmd(req_cmd),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_data(res_data), .res_id(res_id),
        .ops_done(ops_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] d;
        int          id;
    } exp_t;

    exp_t        q[$];
    int          checks = 0;
    int          errors = 0;
    int          m_ptr = 0;
    bit          m_full = 1'b0;
    int          m_pend = -1;
    logic [31:0] m_pend_d;
    int          m_ops = 0;
    logic [N-1:0] m_rdy;

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference shifter from the command rules, using plain operators.
    function automatic logic [31:0] ref_shift(logic [31:0] d, logic [7:0] c);
        int          n;
        logic [63:0] t;
        n = int'(c[4:0]);
        if (c[6]) begin
            if (c[5]) begin
                t = {d, d} >> n;
                return t[31:0];
            end
            t = {d, d} << n;
            return t[63:32];
        end
        if (c[5]) begin
            if (c[7]) return 32'($signed(d) >>> n);
            return d >> n;
        end
        return d << n;
    endfunction

    // Model: decide the grant before each edge and check req_ready.
    always @(negedge clk) begin
        m_pend = -1;
        m_rdy  = '0;
        if (!rst) begin
            if (!m_full || res_ready) begin
                for (int k = 0; k < N; k++) begin
                    int i;
                    i = (m_ptr + k) % N;
                    if (m_pend < 0 && req_valid[i]) m_pend = i;
                end
            end
            if (m_pend >= 0) begin
                m_rdy[m_pend] = 1'b1;
                m_pend_d = ref_shift(req_data[32*m_pend +: 32],
                                     req_cmd[8*m_pend +: 8]);
            end
            chk("req_ready", 64'(req_ready), 64'(m_rdy));
        end
    end

    always @(posedge clk) begin
        if (!rst) begin
            if (m_pend >= 0) begin
                q.push_back('{m_pend_d, m_pend});
                m_ptr  = (m_pend + 1) % N;
                m_full = 1'b1;
            end else if (res_ready) begin
                m_full = 1'b0;
            end
        end
    end

    // Monitor: compare whatever the DUT presents against the queue head.
    always @(negedge clk) begin
        if (!rst) begin
            chk("res_valid", 64'(res_valid), 64'(q.size() != 0));
            chk("ops_done", 64'(ops_done), 64'(m_ops & 16'hFFFF));
            if (res_valid && q.size() != 0) begin
                chk("res_data", 64'(res_data), 64'(q[0].d));
                chk("res_id", 64'(res_id), 64'(q[0].id));
                if (res_ready) begin
                    void'(q.pop_front());
                    m_ops = m_ops + 1;
                end
            end
        end
    end

    task automatic issue(int p, logic [31:0] d, logic [7:0] c, logic [31:0] e);
        req_valid = '0;
        req_valid[p] = 1'b1;
        req_data[32*p +: 32] = d;
        req_cmd[8*p +: 8] = c;
        res_ready = 1'b1;
        @(negedge clk);
        chk("dir_ready", 64'(req_ready[p]), 64'd1);
        @(posedge clk);
        #1 req_valid = '0;
        @(negedge clk);
        chk("dir_valid", 64'(res_valid), 64'd1);
        chk("dir_data", 64'(res_data), 64'(e));
        chk("dir_id", 64'(res_id), 64'(p));
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [31:0]  hold;
        logic [N-1:0] acc;
        req_valid = '1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ready", 64'(req_ready), 64'd0);
        chk("rst_valid", 64'(res_valid), 64'd0);
        chk("rst_data", 64'(res_data), 64'd0);
        chk("rst_id", 64'(res_id), 64'd0);
        chk("rst_ops", 64'(ops_done), 64'd0);
        req_valid = '0;
        rst = 1'b0;
        @(posedge clk);
        #1;

        issue(0, 32'h000000FF, 8'h08, 32'h0000FF00);
        issue(1, 32'h80000000, 8'hA4, 32'hF8000000);
        issue(1, 32'h80000000, 8'h24, 32'h08000000);
        issue(0, 32'h80000001, 8'h61, 32'hC0000000);
        issue(1, 32'h80000001, 8'hE1, 32'hC0000000);
        issue(0, 32'h12345678, 8'h00, 32'h12345678);
        issue(1, 32'h12345678, 8'h9F, 32'h00000000);

        // Both requesters valid: grants alternate starting at 0.
        req_data  = {32'hA5A5_0F0F, 32'h0000_0001};
        req_cmd   = {8'h43, 8'h05};
        req_valid = 2'b11;
        res_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("alt_grant", 64'(req_ready), (i % 2) ? 64'd2 : 64'd1);
            @(posedge clk);
            #1;
        end

        // Stall while FULL.
        res_ready = 1'b0;
        @(negedge clk);
        hold = res_data;
        for (int i = 0; i < 3; i++) begin
            chk("stall_ready", 64'(req_ready), 64'd0);
            chk("stall_data", 64'(res_data), 64'(hold));
            @(posedge clk);
            #1;
            @(negedge clk);
        end
        @(posedge clk);
        #1 res_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 req_valid = '0;
        repeat (2) @(posedge clk);
        #1;

        // Reset while FULL after requester 0 moved the pointer to 1.
        res_ready = 1'b0;
        req_valid = 2'b01;
        @(posedge clk);
        #1 req_valid = 2'b11;
        #2 rst = 1'b1;
        q.delete();
        m_full = 1'b0;
        m_ptr  = 0;
        m_ops  = 0;
        #1;
        chk("mid_rst_valid", 64'(res_valid), 64'd0);
        chk("mid_rst_ops", 64'(ops_done), 64'd0);
        chk("mid_rst_ready", 64'(req_ready), 64'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        res_ready = 1'b1;
        @(negedge clk);
        chk("rst_first", 64'(req_ready), 64'd1);
        @(posedge clk);
        #1;

        // Randomized traffic; operands stay stable until accepted.
        acc = '0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            @(negedge clk);
            acc = req_ready;
            @(posedge clk);
            #1;
            for (int p = 0; p < N; p++) begin
                if (!req_valid[p] || acc[p]) begin
                    req_valid[p] = ($urandom % 3) != 0;
                    req_data[32*p +: 32] = $urandom;
                    req_cmd[8*p +: 8] = 8'($urandom);
                end
            end
            res_ready = ($urandom % 4) != 0;
        end
        req_valid = '0;
        res_ready = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        chk("drain_empty", 64'(q.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
